// File: rtl/cache_pkg.sv
// Shared parameters, address field positions and FSM encoding for the
// 2-way write-through read cache.
package cache_pkg;
  localparam int SETS     = 64;
  localparam int IDX_W    = $clog2(SETS);
  localparam int TAG_W    = 10;
  localparam int DATA_W   = 32;
  localparam int WAYS     = 2;
  localparam int WORDS    = 2;

  localparam int WSEL_BIT = 2;
  localparam int IDX_LSB  = 3;
  localparam int TAG_LSB  = IDX_LSB + IDX_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_W0   = 3'd1;
  localparam logic [2:0] S_RD_W1   = 3'd2;
  localparam logic [2:0] S_WR_THRU = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  typedef struct packed {
    logic [TAG_W-1:0]             tag;
    logic [WORDS-1:0][DATA_W-1:0] data;
  } line_t;

  function automatic logic [31:0] word_adr(logic [31:0] adr, logic word);
    return {adr[31:3], word, 2'b00};
  endfunction
endpackage

// File: rtl/cache_if.sv
// Pipeline-side and SRAM-side buses of the cache. Master drives requests.
interface cache_mem_if;
  logic                        mem_rd_en;
  logic                        mem_wr_en;
  logic [31:0]                 mem_adr;
  logic [cache_pkg::DATA_W-1:0] mem_wr_data;
  logic [cache_pkg::DATA_W-1:0] mem_rd_data;
  logic                        ready;

  modport master (output mem_rd_en, mem_wr_en, mem_adr, mem_wr_data,
                  input  mem_rd_data, ready);
  modport slave  (input  mem_rd_en, mem_wr_en, mem_adr, mem_wr_data,
                  output mem_rd_data, ready);
endinterface

interface cache_sram_if;
  logic                        sram_rd_en;
  logic                        sram_wr_en;
  logic [31:0]                 sram_adr;
  logic [cache_pkg::DATA_W-1:0] sram_wr_data;
  logic [cache_pkg::DATA_W-1:0] sram_rd_data;
  logic                        sram_ready;

  modport master (output sram_rd_en, sram_wr_en, sram_adr, sram_wr_data,
                  input  sram_rd_data, sram_ready);
  modport slave  (input  sram_rd_en, sram_wr_en, sram_adr, sram_wr_data,
                  output sram_rd_data, sram_ready);
endinterface

// File: rtl/cache_set_array.sv
// Tag/valid/data storage per way plus one LRU bit per set.
// Async read by index, sync write; valid and LRU clear on reset.
module cache_set_array
  import cache_pkg::*;
#(
  parameter int N_SETS = SETS,
  parameter int IW     = $clog2(N_SETS)
) (
  input  logic                                 clk,
  input  logic                                 i_rst_n,
  input  logic [IW-1:0]                        i_idx,
  output logic [WAYS-1:0]                      o_valid,
  output logic [WAYS-1:0][TAG_W-1:0]           o_tag,
  output logic [WAYS-1:0][WORDS-1:0][DATA_W-1:0] o_data,
  output logic                                 o_lru,
  input  logic                                 i_fill_en,
  input  logic                                 i_fill_way,
  input  line_t                                i_fill_line,
  input  logic                                 i_wr_en,
  input  logic                                 i_wr_way,
  input  logic                                 i_wr_word,
  input  logic [DATA_W-1:0]                    i_wr_data,
  input  logic                                 i_lru_we,
  input  logic                                 i_lru_val
);
  logic [N_SETS-1:0] r_lru;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [N_SETS-1:0]            r_valid;
    logic [TAG_W-1:0]             r_tag  [N_SETS];
    logic [WORDS-1:0][DATA_W-1:0] r_data [N_SETS];
    logic                         w_fill;
    logic                         w_wr;

    assign w_fill = i_fill_en && (i_fill_way == 1'(w));
    assign w_wr   = i_wr_en   && (i_wr_way   == 1'(w));

    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_valid <= '0;
      else if (w_fill) r_valid[i_idx] <= 1'b1;
    end

    // Tag/data carry no reset: valid gates every use.
    always_ff @(posedge clk) begin
      if (w_fill) begin
        r_tag[i_idx]  <= i_fill_line.tag;
        r_data[i_idx] <= i_fill_line.data;
      end else if (w_wr) begin
        r_data[i_idx][i_wr_word] <= i_wr_data;
      end
    end

    assign o_valid[w] = r_valid[i_idx];
    assign o_tag[w]   = r_tag[i_idx];
    assign o_data[w]  = r_data[i_idx];
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_lru <= '0;
    else if (i_lru_we) r_lru[i_idx] <= i_lru_val;
  end

  assign o_lru = r_lru[i_idx];
endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through, no-write-allocate cache between the
// MEM stage and the SRAM controller. Read hits complete combinationally.
module cache_controller
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cache_mem_if.slave   mem,
  cache_sram_if.master sram
);
  logic [2:0]        r_state, w_next;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_done_data;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic              w_wsel;
  logic              w_unused;

  logic [WAYS-1:0]                        w_valid;
  logic [WAYS-1:0][TAG_W-1:0]             w_tags;
  logic [WAYS-1:0][WORDS-1:0][DATA_W-1:0] w_data;
  logic                                   w_lru;

  logic w_hit0, w_hit1, w_hit;
  logic w_rd_req, w_any_req;
  logic w_rdhit, w_wrhit, w_fill_en, w_lru_we, w_lru_val;
  logic [DATA_W-1:0] w_hit_word;
  line_t             w_fill_line;

  assign w_tag    = mem.mem_adr[TAG_LSB +: TAG_W];
  assign w_idx    = mem.mem_adr[IDX_LSB +: IDX_W];
  assign w_wsel   = mem.mem_adr[WSEL_BIT];
  assign w_unused = ^mem.mem_adr[1:0];

  // Way0 takes precedence if both ways ever claim the same tag.
  assign w_hit0     = w_valid[0] && (w_tags[0] == w_tag);
  assign w_hit1     = w_valid[1] && (w_tags[1] == w_tag) && !w_hit0;
  assign w_hit      = w_hit0 || w_hit1;
  assign w_hit_word = w_hit1 ? w_data[1][w_wsel] : w_data[0][w_wsel];

  // Write wins when both enables are raised.
  assign w_rd_req  = mem.mem_rd_en && !mem.mem_wr_en;
  assign w_any_req = mem.mem_rd_en || mem.mem_wr_en;
  assign w_rdhit   = (r_state == S_IDLE) && w_rd_req && w_hit;
  assign w_wrhit   = (r_state == S_IDLE) && mem.mem_wr_en && w_hit;
  assign w_fill_en = (r_state == S_RD_W1) && sram.sram_ready;

  // LRU names the way to replace next, so it points away from the accessed way.
  assign w_lru_we  = w_rdhit || w_wrhit || w_fill_en;
  assign w_lru_val = w_fill_en ? ~w_lru : ~w_hit1;

  assign w_fill_line.tag  = w_tag;
  assign w_fill_line.data = {sram.sram_rd_data, r_buf0};

  cache_set_array u_array (
    .clk         (clk),
    .i_rst_n     (rst),
    .i_idx       (w_idx),
    .o_valid     (w_valid),
    .o_tag       (w_tags),
    .o_data      (w_data),
    .o_lru       (w_lru),
    .i_fill_en   (w_fill_en),
    .i_fill_way  (w_lru),
    .i_fill_line (w_fill_line),
    .i_wr_en     (w_wrhit),
    .i_wr_way    (w_hit1),
    .i_wr_word   (w_wsel),
    .i_wr_data   (mem.mem_wr_data),
    .i_lru_we    (w_lru_we),
    .i_lru_val   (w_lru_val)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem.mem_wr_en)          w_next = S_WR_THRU;
        else if (w_rd_req && !w_hit) w_next = S_RD_W0;
      end
      S_RD_W0:   if (sram.sram_ready) w_next = S_RD_W1;
      S_RD_W1:   if (sram.sram_ready) w_next = S_DONE;
      S_WR_THRU: if (sram.sram_ready) w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_buf0      <= '0;
      r_done_data <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_RD_W0) && sram.sram_ready) r_buf0 <= sram.sram_rd_data;
      if (w_fill_en) r_done_data <= w_wsel ? sram.sram_rd_data : r_buf0;
    end
  end

  // SRAM request is a pure function of state and the held pipeline inputs,
  // so it stays stable until sram_ready moves the FSM on.
  always_comb begin
    sram.sram_rd_en   = 1'b0;
    sram.sram_wr_en   = 1'b0;
    sram.sram_adr     = '0;
    sram.sram_wr_data = '0;
    case (r_state)
      S_RD_W0: begin
        sram.sram_rd_en = 1'b1;
        sram.sram_adr   = word_adr(mem.mem_adr, 1'b0);
      end
      S_RD_W1: begin
        sram.sram_rd_en = 1'b1;
        sram.sram_adr   = word_adr(mem.mem_adr, 1'b1);
      end
      S_WR_THRU: begin
        sram.sram_wr_en   = 1'b1;
        sram.sram_adr     = word_adr(mem.mem_adr, w_wsel);
        sram.sram_wr_data = mem.mem_wr_data;
      end
      default: ;
    endcase
  end

  assign mem.ready = !rst
                  || ((r_state == S_IDLE) && (!w_any_req || w_rdhit))
                  || (r_state == S_DONE);

  always_comb begin
    mem.mem_rd_data = '0;
    if (w_rdhit)                 mem.mem_rd_data = w_hit_word;
    else if (r_state == S_DONE)  mem.mem_rd_data = r_done_data;
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench: a 2-entry-per-set LRU list model predicts
// hit/miss, SRAM traffic and read data; a monitor checks each completion.
module tb_cache_controller;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_mem_if  mem ();
  cache_sram_if sram ();

  cache_controller dut (
    .clk  (clk),
    .rst  (rst),
    .mem  (mem),
    .sram (sram)
  );

  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    bit          stable;
  } txn_t;

  typedef struct {
    bit          is_wr;
    bit          hit;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  txn_t obs_q[$];
  exp_t exp_q[$];
  bit   both_en_seen = 1'b0;

  logic [31:0] sram_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [9:0]  m_t [64][2];   // per set: [0]=least recent, [1]=most recent
  int          m_n [64];

  function automatic logic [31:0] seed_val(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chkb(string name, bit act, bit expv);
    chk(name, {31'd0, act}, {31'd0, expv});
  endtask

  function automatic int m_find(int idx, logic [9:0] tg);
    for (int p = 0; p < m_n[idx]; p++)
      if (m_t[idx][p] == tg) return p;
    return -1;
  endfunction

  task automatic m_touch(int idx, int p);
    logic [9:0] t;
    if (m_n[idx] == 2 && p == 0) begin
      t = m_t[idx][0];
      m_t[idx][0] = m_t[idx][1];
      m_t[idx][1] = t;
    end
  endtask

  task automatic m_fill(int idx, logic [9:0] tg);
    if (m_n[idx] < 2) begin
      m_t[idx][m_n[idx]] = tg;
      m_n[idx]++;
    end else begin
      m_t[idx][0] = m_t[idx][1];
      m_t[idx][1] = tg;
    end
  endtask

  // SRAM controller model: random 1..5 cycle latency, records each transaction.
  initial begin
    int   cnt;
    int   lat;
    txn_t cur;
    cnt = 0;
    lat = 1;
    cur = '{0, 0, 0, 0};
    sram.sram_ready   = 1'b0;
    sram.sram_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      sram.sram_ready   = 1'b0;
      sram.sram_rd_data = $urandom;
      if (!rst) begin
        cnt = 0;
        continue;
      end
      if (sram.sram_rd_en && sram.sram_wr_en) both_en_seen = 1'b1;
      if (sram.sram_rd_en || sram.sram_wr_en) begin
        if (cnt == 0) begin
          cur.wr = sram.sram_wr_en; cur.adr = sram.sram_adr;
          cur.wdata = sram.sram_wr_data; cur.stable = 1'b1;
          lat = $urandom_range(1, 5);
        end else if (cur.wr != sram.sram_wr_en || cur.adr !== sram.sram_adr
                     || cur.wdata !== sram.sram_wr_data) begin
          cur.stable = 1'b0;
        end
        cnt++;
        if (cnt >= lat) begin
          sram.sram_ready = 1'b1;
          if (cur.wr) sram_mem[cur.adr] = cur.wdata;
          else sram.sram_rd_data = sram_mem.exists(cur.adr) ? sram_mem[cur.adr]
                                                            : seed_val(cur.adr);
          obs_q.push_back(cur);
          cnt = 0;
        end
      end else if (cnt != 0) begin
        cur.stable = 1'b0;
        obs_q.push_back(cur);
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the cache completes a request.
  initial begin
    int          lat;
    int          n;
    exp_t        e;
    logic [31:0] ea;
    lat = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        lat = 0;
        continue;
      end
      if (mem.mem_rd_en || mem.mem_wr_en) begin
        if (!mem.ready) lat++;
        else begin
          if (exp_q.size() == 0) chkb("unexpected_done", 1'b1, 1'b0);
          else begin
            e = exp_q.pop_front();
            if (!e.is_wr) chk("rd_data", mem.mem_rd_data, e.rdata);
            chkb("zero_latency_hit", lat == 0, !e.is_wr && e.hit);
            n = e.is_wr ? 1 : (e.hit ? 0 : 2);
            chk("sram_txn_count", 32'(obs_q.size()), 32'(n));
            if (obs_q.size() == n) begin
              for (int k = 0; k < n; k++) begin
                ea = e.is_wr ? {e.adr[31:2], 2'b00} : {e.adr[31:3], 1'(k), 2'b00};
                chkb("sram_txn_kind", obs_q[k].wr, e.is_wr);
                chk("sram_adr", obs_q[k].adr, ea);
                if (e.is_wr) chk("sram_wr_data", obs_q[k].wdata, e.wdata);
                chkb("sram_req_stable", obs_q[k].stable, 1'b1);
              end
            end
          end
          obs_q.delete();
          lat = 0;
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the handshake edge.
  task automatic req(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    exp_t        e;
    int          idx;
    int          p;
    int          n;
    logic [9:0]  tg;
    logic [31:0] wa;
    idx = int'(a[8:3]);
    tg  = a[18:9];
    wa  = {a[31:2], 2'b00};
    p   = m_find(idx, tg);
    e.is_wr = wr; e.hit = (p >= 0); e.adr = a; e.wdata = d; e.rdata = ref_rd(wa);
    if (wr) begin
      ref_mem[wa] = d;
      if (p >= 0) m_touch(idx, p);
    end else if (p >= 0) m_touch(idx, p);
    else m_fill(idx, tg);
    exp_q.push_back(e);
    mem.mem_rd_en = rd; mem.mem_wr_en = wr; mem.mem_adr = a; mem.mem_wr_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem.ready && n < 200);
    if (!mem.ready) chkb("req_timeout", 1'b0, 1'b1);
    @(posedge clk); #2;
  endtask

  task automatic idle(int cyc);
    mem.mem_rd_en = 1'b0; mem.mem_wr_en = 1'b0; mem.mem_adr = $urandom;
    repeat (cyc) @(posedge clk);
    #2;
  endtask

  task automatic reset_mid(logic [31:0] a);
    int n;
    mem.mem_rd_en = 1'b1; mem.mem_wr_en = 1'b0; mem.mem_adr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sram.sram_rd_en && sram.sram_adr[2]) && n < 100);
    chkb("reach_second_word", sram.sram_rd_en && sram.sram_adr[2], 1'b1);
    rst = 1'b0;
    #1;
    chkb("rst_mid_ready", mem.ready, 1'b1);
    chkb("rst_mid_sram_rd_en", sram.sram_rd_en, 1'b0);
    chk("rst_mid_sram_adr", sram.sram_adr, 32'd0);
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 64; i++) m_n[i] = 0;
    mem.mem_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
  endtask

  initial begin
    logic [31:0] a;
    logic [9:0]  tg;
    logic [5:0]  ix;
    int          op;
    mem.mem_rd_en = 1'b0; mem.mem_wr_en = 1'b0;
    mem.mem_adr = '0; mem.mem_wr_data = '0;
    for (int i = 0; i < 64; i++) m_n[i] = 0;
    sram_mem[32'h100] = 32'h1111_1111; ref_mem[32'h100] = 32'h1111_1111;
    sram_mem[32'h104] = 32'h2222_2222; ref_mem[32'h104] = 32'h2222_2222;

    #3;
    chkb("reset_ready", mem.ready, 1'b1);
    chkb("reset_sram_rd_en", sram.sram_rd_en, 1'b0);
    chkb("reset_sram_wr_en", sram.sram_wr_en, 1'b0);
    chk("reset_sram_adr", sram.sram_adr, 32'd0);
    chk("reset_sram_wr_data", sram.sram_wr_data, 32'd0);
    chk("reset_rd_data", mem.mem_rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    chkb("idle_ready", mem.ready, 1'b1);

    req(1, 0, 32'h0000_0100, 32'h0);
    req(1, 0, 32'h0000_0104, 32'h0);
    req(1, 0, 32'h0000_0300, 32'h0);
    req(1, 0, 32'h0000_0500, 32'h0);
    req(1, 0, 32'h0000_0300, 32'h0);
    req(1, 0, 32'h0000_0100, 32'h0);
    idle(1);
    req(0, 1, 32'h0000_0104, 32'hDEAD_BEEF);
    req(1, 0, 32'h0000_0104, 32'h0);
    req(0, 1, 32'h0000_0800, 32'h1234_5678);
    req(1, 0, 32'h0000_0800, 32'h0);
    idle(2);
    reset_mid(32'h0000_1000);
    req(1, 0, 32'h0000_1000, 32'h0);
    req(1, 1, 32'h0000_1004, 32'hCAFE_F00D);
    req(1, 0, 32'h0000_1004, 32'h0);

    for (int i = 0; i < 160; i++) begin
      op = $urandom_range(0, 9);
      tg = 10'($urandom_range(0, 3));
      ix = ($urandom_range(0, 1) != 0 ? 6'd32 : 6'd0) + 6'($urandom_range(0, 1));
      a  = {13'd0, tg, ix, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      if (op < 6)      req(1, 0, a, $urandom);
      else if (op < 9) req(0, 1, a, $urandom);
      else             req(1, 1, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    chkb("never_both_enables", both_en_seen, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
